// File: rtl/jpeg_tile_sched.sv
// Frame sequencer: walks an RGB frame in 8x8 tile order and feeds jpeg_topfour.
// Optional WAIT_DONE watchdog enabled by defining JPEG_SCHED_TIMEOUT_EN.
module jpeg_tile_sched #(
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              error,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic              core_start,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              pixel_valid,
  input  logic              core_done,
  output logic [7:0]        tile_x,
  output logic [7:0]        tile_y
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam logic [7:0] TX_LAST = 8'(IMG_W / 8 - 1);
  localparam logic [7:0] TY_LAST = 8'(IMG_H / 8 - 1);

  logic [1:0]        state_q, state_d;
  logic [6:0]        pix_q, pix_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        ty_q, ty_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pv_q;
  logic              fd_q, fd_d;

`ifdef JPEG_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
`endif

  logic [31:0] row;
  logic [31:0] col;
  logic [31:0] addr_full;
  logic        last_tile;

  // Full-width raster address; truncated only when registered
  assign row       = 32'({ty_q, 3'b000}) + 32'(pix_q[5:3]);
  assign col       = 32'({tx_q, 3'b000}) + 32'(pix_q[2:0]);
  assign addr_full = row * 32'(IMG_W) + col;
  assign last_tile = (tx_q == TX_LAST) && (ty_q == TY_LAST);

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    fd_d    = 1'b0;
`ifdef JPEG_SCHED_TIMEOUT_EN
    wcnt_d  = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_START;
          tx_d    = '0;
          ty_d    = '0;
`ifdef JPEG_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_START: begin
        state_d = S_FETCH;
        pix_d   = '0;
      end
      S_FETCH: begin
        // pix_q[6] marks all 64 reads issued
        if (pix_q[6]) begin
          state_d = S_WAIT;
        end else begin
          rd_d   = 1'b1;
          addr_d = addr_full[ADDR_W-1:0];
          pix_d  = pix_q + 7'd1;
        end
      end
      S_WAIT: begin
        if (core_done) begin
          if (last_tile) begin
            state_d = S_IDLE;
            fd_d    = 1'b1;
          end else begin
            state_d = S_START;
            if (tx_q == TX_LAST) begin
              tx_d = '0;
              ty_d = ty_q + 8'd1;
            end else begin
              tx_d = tx_q + 8'd1;
            end
          end
`ifdef JPEG_SCHED_TIMEOUT_EN
        end else if (wcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      pv_q    <= 1'b0;
      fd_q    <= 1'b0;
`ifdef JPEG_SCHED_TIMEOUT_EN
      wcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      pv_q    <= rd_q;
      fd_q    <= fd_d;
`ifdef JPEG_SCHED_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign core_start  = (state_q == S_START);
  assign frame_done  = fd_q;
  assign mem_rd      = rd_q;
  assign mem_addr    = addr_q;
  assign pixel_valid = pv_q;
  assign tile_x      = tx_q;
  assign tile_y      = ty_q;
  assign R           = mem_rdata[23:16];
  assign G           = mem_rdata[15:8];
  assign B           = mem_rdata[7:0];

`ifdef JPEG_SCHED_TIMEOUT_EN
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/jpeg_tile_sched.md
# jpeg_tile_sched

Frame-level sequencer for the JPEG colour-convert/DCT core (`jpeg_topfour`). It walks an RGB image held in a synchronous frame memory in 8x8 tile order. For each tile it issues a one-cycle `start` to the core, streams the 64 pixels with `pixel_valid`, and waits for the core's `done` before moving to the next tile. It sits between the frame buffer and the core, and replaces testbench-driven pixel feeding in the integrated design.

## Interface
Parameters:
- `IMG_W`, default 64: image width in pixels; a multiple of 8, ≥ 8.
- `IMG_H`, default 64: image height in pixels; a multiple of 8, ≥ 8.
- `ADDR_W`, default 12: memory address width; must be ≥ clog2(IMG_W*IMG_H).
- `TIMEOUT_CYC`, default 1024: watchdog limit in cycles. Used only with `JPEG_SCHED_TIMEOUT_EN`.

Ports:
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `frame_start` input, 1 bit: starts a frame when sampled high in IDLE.
- `busy` output, 1 bit: high in any state other than IDLE.
- `frame_done` output, 1 bit: one-cycle pulse after the last tile's `core_done`.
- `error` output, 1 bit: sticky watchdog flag; cleared by `frame_start` or reset.
- `mem_rd` output, 1 bit: frame-memory read enable.
- `mem_addr` output, ADDR_W bits: raster pixel address.
- `mem_rdata` input, 24 bits: {R[23:16], G[15:8], B[7:0]}; valid one cycle after `mem_rd`.
- `core_start` output, 1 bit: to core `start`.
- `R`, `G`, `B` outputs, 8 bits each: to the core; combinational slices of `mem_rdata`.
- `pixel_valid` output, 1 bit: to core `pixel_valid`; this is `mem_rd` delayed by one registered cycle.
- `core_done` input, 1 bit: core `done`.
- `tile_x`, `tile_y` outputs, 8 bits each: index of the current tile.

## Operation
- States:
  - IDLE: waits for `frame_start`.
  - START: `core_start`=1 for exactly one cycle.
  - FETCH: 64 cycles with `mem_rd`=1.
  - WAIT_DONE: waits for `core_done`.
- Transitions:
  - IDLE→START on `frame_start`. Tile indices clear to 0 and `error` clears.
  - START→FETCH unconditionally.
  - FETCH→WAIT_DONE after the 64th read (pixel counter `pix` reaches 63).
  - WAIT_DONE on `core_done`:
    - Last tile (`tile_x`=IMG_W/8−1 and `tile_y`=IMG_H/8−1): go to IDLE and pulse `frame_done`.
    - Otherwise: advance the tile and go to START.
- Tile order: raster over tiles. `tile_x` increments first; when it wraps to 0, `tile_y` increments.
- Pixel order within a tile: raster. Row r = pix[5:3], column c = pix[2:0].
- `mem_addr` = (tile_y*8 + r)*IMG_W + tile_x*8 + c. It is computed in full width, then truncated to ADDR_W.
- Outside FETCH, `mem_addr` holds the last value.
- `core_done` is sampled only in WAIT_DONE. Pulses in any other state are ignored.
- `frame_start` while `busy` is ignored.
- Reset, at any point including mid-frame, forces these values at the next edge:
  - state IDLE;
  - `busy`, `frame_done`, `error`, `mem_rd`, `core_start`, `pixel_valid` all 0;
  - `mem_addr`, `tile_x`, `tile_y` all 0.

## Timing
- Let E0 be the edge that samples `frame_start`=1 in IDLE.
- Cycle after E0: `core_start`=1, `busy`=1.
- Cycles after E2..E65: `mem_rd`=1 with addresses for pix 0..63.
- Cycles after E3..E66: `pixel_valid`=1, and R/G/B carry pixels 0..63.
- WAIT_DONE starts after E66.
- `core_done` sampled at edge Ed:
  - Not the last tile: `core_start` is high in the next cycle, so the inter-tile overhead is 1 cycle plus core latency.
  - Last tile: `frame_done`=1 for the cycle after Ed, and `busy`=0 in that same cycle.
- Throughput: one pixel per cycle in FETCH, with no bubbles inside a tile.

## Configuration
- `JPEG_SCHED_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DONE.
  - If TIMEOUT_CYC cycles pass without `core_done`: set `error`=1, go to IDLE, and do not pulse `frame_done`.
- `JPEG_SCHED_TIMEOUT_EN` undefined:
  - No counter; WAIT_DONE waits indefinitely.
  - `error` is tied to 0.

## Test plan
- IMG_W=IMG_H=16, memory word = address, core model asserts `done` 20 cycles after the last `pixel_valid`:
  - 4 tiles, 4 `core_start` pulses, 256 `pixel_valid` cycles, one `frame_done`.
  - First addresses per tile: 0, 8, 128, 136. Last address 255.
- Tile (1,0) stream: row 1 begins at address 24 (pix 8). Check R/G/B equal `mem_rdata` fields, aligned with `pixel_valid`.
- `core_done` pulsed during FETCH and during START → ignored; the sequence is unchanged and completes normally.
- `frame_start` held high through the whole frame → exactly one frame runs. A new frame starts only if `frame_start` is still high when the block is back in IDLE.
- `rst_n`=0 for one cycle at pix 30 of tile 2 → all outputs return to reset values at the next edge. A later `frame_start` restarts at tile (0,0), address 0.
- With `JPEG_SCHED_TIMEOUT_EN` and TIMEOUT_CYC=50, core never asserts `done` → `error`=1 after 50 WAIT_DONE cycles, `busy`=0, no `frame_done`. A following `frame_start` clears `error`.
